dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised byte-addressable data memory with a built-in load/store front end for the RISC-V core's MEM stage.
- Storage is organised as 4 byte lanes of DEPTH_BYTES/4 words each.
- Handles byte, half and word accesses with sign or zero extension, out-of-range detection and a registered read.
- Misaligned accesses are split into two beats by a small FSM; responses use a valid/ready request plus one-cycle response pulse.

Parameters:
- ADDR_W, 12: byte-address bits decoded; DEPTH_BYTES = 2**ADDR_W.
- LANES, 4: byte lanes per word; fixed at 4 for a 32-bit datapath and checked at elaboration.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  load zero-extend (LBU/LHU) when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access fault, qualified by rsp_valid.

Behaviour:
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, FSM = IDLE. Memory contents are not cleared (undefined after power-up).
- FSM states:
  - IDLE: req_ready = 1.
  - BEAT2: req_ready = 0; performs the second word of a split access.
  - Transitions: IDLE -> BEAT2 on an accepted misaligned, non-faulting request. BEAT2 -> IDLE always, after one cycle.
- Aligned access accepted in cycle N: lane RAMs are read/written at word addr[ADDR_W-1:2]. rsp_valid = 1 in cycle N+1. Back-to-back requests are sustained at one per cycle.
- Byte enables: byte = 1 << addr[1:0]; half = 2'b11 << addr[1:0]; word = 4'b1111. Store data is rotated left by 8*addr[1:0] before lane write.
- Load extraction: the read word is rotated right by 8*addr[1:0], then bit 7 (byte) or bit 15 (half) is sign-extended unless req_unsigned.
- A request is misaligned when it spans two words: half with addr[1:0] = 3, or word with addr[1:0] != 0.
  - Beat 1 (cycle N) covers word A with the lower lanes.
  - Beat 2 (cycle N+1) covers word A+1 with the remaining lanes.
  - Load data is merged from both beats; rsp_valid asserts in cycle N+2.
- Fault (rsp_err = 1, rsp_rdata = 0, no lane written), response one cycle after the last beat:
  - req_size = 3.
  - Any byte of the access is at or above DEPTH_BYTES, including the second beat of a split access (checked at acceptance).
  - req_addr[31:ADDR_W] != 0.
- Store response: rsp_valid pulses with rsp_rdata = 0.
- Read-during-write to the same word in the same cycle returns old data; a load in the following cycle returns the new data.
- Reset asserted mid-split: FSM returns to IDLE and no response is produced. A beat-1 write already clocked stays committed; the beat-2 write is lost.
- Reset asserted during a pending rsp_valid: the pulse is dropped.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined: misaligned accesses are split in two beats as described above.
- Undefined: BEAT2 is not built, req_ready is tied to 1, and any misaligned request faults: rsp_err = 1 in cycle N+1, no write.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2;
  - FSM state encoding IDLE/BEAT2;
  - lane count constant LANES = 4.
- Sub-module dmem_lane: one 8-bit-wide, DEPTH_BYTES/4-deep RAM with synchronous write enable and registered read. It is instantiated LANES times.

Test Plan:
- Store word 0xDEADBEEF at 0x010, load word at 0x010 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid one cycle after acceptance.
- After the above, LB at 0x013 -> 0xFFFFFFDE; LBU at 0x013 -> 0x000000DE; LH at 0x012 -> 0xFFFFDEAD.
- SB 0x55 at 0x011, then LW at 0x010 -> 0xDEAD55EF; only lane 1 is written.
- With DMEM_MISALIGN_EN: SW 0x11223344 at 0x023, LW at 0x023 -> 0x11223344, rsp_valid 2 cycles after acceptance, req_ready low for 1 cycle. LW at 0x020 -> 0x44xxxxxx with only byte 3 changed.
- Without DMEM_MISALIGN_EN: LH at 0x003 -> rsp_err = 1 after 1 cycle. A following LW at 0x000 returns the unmodified contents.
- LW at DEPTH_BYTES (0x1000) -> rsp_err = 1. SW at 0xFFE (ADDR_W = 12, split over the end) -> rsp_err = 1, and LH at 0xFFE shows the old value. Assert rst_n low in BEAT2 -> no rsp_valid, req_ready = 1 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_lsu data memory: access size encodings,
// split-access FSM states, lane count and byte-rotation helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int LANES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } state_t;

  // Rotate a word left by n whole bytes (moves LSB-aligned data onto its lanes).
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0],  d[31:8]};
    endcase
    return r;
  endfunction

  // Rotate a word right by n whole bytes (brings lane data back to LSB-aligned).
  function automatic logic [31:0] rotr_bytes(input logic [31:0] d, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = d;
      2'd1:    r = {d[7:0],  d[31:8]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[23:0], d[31:24]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// One byte lane of the data memory: 8-bit wide RAM with synchronous write
// and registered read. A same-address read during a write returns old data.
module dmem_lane #(
  parameter int WORD_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**WORD_W];

  // Lane access: write when enabled and write-enabled, read old contents every enabled cycle.
  // NOTE: RAM arrays carry no reset so they map onto memory macros; contents are undefined after power-up.
  // NOTE: non-blocking assignments here make the read see the pre-write value on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with load/store front end for the MEM stage.
// Four dmem_lane byte lanes, byte/half/word access with sign/zero extension,
// fault detection and a registered read (response one cycle after accept).
// Build option DMEM_MISALIGN_EN: when defined, accesses spanning two words are
// split into two beats by a small FSM; when undefined they fault instead.
module dmem_lsu #(
  parameter int ADDR_W = 12,
  parameter int LANES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  import dmem_pkg::SIZE_B, dmem_pkg::SIZE_H, dmem_pkg::SIZE_W;
  import dmem_pkg::state_t, dmem_pkg::IDLE, dmem_pkg::BEAT2;
  import dmem_pkg::rotl_bytes, dmem_pkg::rotr_bytes;

  localparam int WORD_W      = ADDR_W - 2;
  localparam int DEPTH_BYTES = 2 ** ADDR_W;

  if (LANES != dmem_pkg::LANES) begin : g_lanes_check
    $error("dmem_lsu: LANES must be 4 for the 32-bit datapath");
  end

  // Request decode
  logic              accept;
  logic              in_beat2;
  logic              split;
  logic              misal;
  logic              fault;
  logic              fault_base;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [1:0]        last_off;
  logic [7:0]        be_full;
  logic [ADDR_W:0]   end_addr;
  logic [WORD_W-1:0] word_a;
  logic [31:0]       wdata_rot;

  // Lane interface
  logic [WORD_W-1:0] lane_addr;
  logic              lane_en;
  logic [LANES-1:0]  lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  // Response metadata captured at acceptance
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_we;
  logic              r_err;
  logic [31:0]       merged;
  logic [31:0]       rot;
  logic [31:0]       ext;

  // Size decode: lane mask and offset of the last byte within the access.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    mask     = 4'b0000;
    last_off = 2'd0;
    case (req_size)
      SIZE_B:  begin mask = 4'b0001; last_off = 2'd0; end
      SIZE_H:  begin mask = 4'b0011; last_off = 2'd1; end
      SIZE_W:  begin mask = 4'b1111; last_off = 2'd3; end
      default: ;
    endcase
  end

  assign off       = req_addr[1:0];
  assign word_a    = req_addr[ADDR_W-1:2];
  assign be_full   = {4'b0000, mask} << off;
  assign misal     = |be_full[7:4];
  assign end_addr  = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(last_off);
  assign wdata_rot = rotl_bytes(req_wdata, off);

  // Reserved size (empty mask), upper address bits set, or last byte past the end.
  assign fault_base = (mask == 4'b0000)
                    | (|req_addr[31:ADDR_W])
                    | (end_addr > (ADDR_W+1)'(DEPTH_BYTES - 1));

  assign req_ready = ~in_beat2;
  assign accept    = req_valid & req_ready;

`ifdef DMEM_MISALIGN_EN
  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] b2_word;
  logic [3:0]        b2_be;
  logic              b2_we;
  logic [31:0]       b2_wdata;
  logic [31:0]       lo_data;
  logic              r_split;

  assign fault    = fault_base;
  assign split    = misal & ~fault_base;
  assign in_beat2 = (state == BEAT2);

  // Split-access FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Split-access FSM next state: one extra cycle for the second word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && split) state_next = BEAT2;
      BEAT2:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Second-beat context: next word, its lanes and the rotated store data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b2_word  <= '0;
      b2_be    <= 4'b0000;
      b2_we    <= 1'b0;
      b2_wdata <= 32'd0;
    end else if (accept && split) begin
      b2_word  <= word_a + WORD_W'(1);
      b2_be    <= be_full[7:4];
      b2_we    <= req_we;
      b2_wdata <= wdata_rot;
    end
  end

  // Hold the first-beat read word while the second word is fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lo_data <= 32'd0;
    else if (in_beat2) lo_data <= lane_rdata;
  end

  // Remember whether the pending response must merge two beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_split <= 1'b0;
    else if (accept) r_split <= split;
  end
`else
  assign fault    = fault_base | misal;
  assign split    = 1'b0;
  assign in_beat2 = 1'b0;
`endif

  // Lane drive: the accepted request, or the stored second beat of a split access.
  always_comb begin
    lane_addr  = word_a;
    lane_en    = accept & ~fault;
    lane_we    = (accept && req_we && !fault) ? be_full[3:0] : 4'b0000;
    lane_wdata = wdata_rot;
`ifdef DMEM_MISALIGN_EN
    if (in_beat2) begin
      lane_addr  = b2_word;
      lane_en    = 1'b1;
      lane_we    = b2_we ? b2_be : 4'b0000;
      lane_wdata = b2_wdata;
    end
`endif
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dmem_lane #(
      .WORD_W (WORD_W)
    ) u_lane (
      .clk   (clk),
      .en    (lane_en),
      .we    (lane_we[i]),
      .addr  (lane_addr),
      .wdata (lane_wdata[8*i +: 8]),
      .rdata (lane_rdata[8*i +: 8])
    );
  end

  // Capture what the response path needs to shape the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off  <= 2'd0;
      r_size <= SIZE_B;
      r_uns  <= 1'b0;
      r_we   <= 1'b0;
      r_err  <= 1'b0;
    end else if (accept) begin
      r_off  <= off;
      r_size <= req_size;
      r_uns  <= req_unsigned;
      r_we   <= req_we;
      r_err  <= fault;
    end
  end

  // Response pulse: one cycle after an unsplit accept, or after the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_valid <= 1'b0;
    else        rsp_valid <= (accept & ~split) | in_beat2;
  end

  // Load data: merge beats, realign to LSB, then sign or zero extend.
  always_comb begin
    merged = lane_rdata;
`ifdef DMEM_MISALIGN_EN
    for (int i = 0; i < LANES; i++) begin
      if (r_split && !b2_be[i]) merged[8*i +: 8] = lo_data[8*i +: 8];
    end
`endif
    rot = rotr_bytes(merged, r_off);
    case (r_size)
      SIZE_B:  ext = {{24{~r_uns & rot[7]}},  rot[7:0]};
      SIZE_H:  ext = {{16{~r_uns & rot[15]}}, rot[15:0]};
      default: ext = rot;
    endcase
    rsp_rdata = (rsp_valid && !r_err && !r_we) ? ext : 32'd0;
  end

  assign rsp_err = rsp_valid & r_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a byte-level reference memory produces the
// expected response of every accepted request, which a monitor compares
// (data, error and latency) when the DUT pulses rsp_valid.
module tb_dmem_lsu;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_lsu #(
    .ADDR_W (12),
    .LANES  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  string      tag_q[$];
  logic [7:0] mem_model [DEPTH];
  int         cyc = 0;
  int         assert_cnt = 0;
  int         fail_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic spans_two(input logic [1:0] size, input logic [31:0] addr);
    return (int'(addr[1:0]) + nbytes(size) - 1) > 3;
  endfunction

  function automatic logic exp_fault(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    nb = nbytes(size);
    if (nb == 0) return 1'b1;
    if (addr[31:12] != 20'd0) return 1'b1;
    if (int'(addr[11:0]) + nb - 1 > DEPTH - 1) return 1'b1;
`ifndef DMEM_MISALIGN_EN
    if (spans_two(size, addr)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Monitor: compare every response against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_rdata"},   rsp_rdata, e.rdata);
        check({t, "_err"},     {31'd0, rsp_err}, {31'd0, e.err});
        check({t, "_latency"}, cyc - e.acc_cyc, e.lat);
      end
    end
  end

  // Issue one request (called at posedge+1), push its expected response, return after accept.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          nb;
    int          waited;
    logic [31:0] v;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waited = 0;
    while (!req_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      check({tag, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    nb      = nbytes(size);
    e.err   = exp_fault(size, addr);
    e.lat   = (!e.err && spans_two(size, addr)) ? 2 : 1;
    e.rdata = 32'd0;
    e.acc_cyc = cyc;
    if (!e.err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem_model[int'(addr[11:0]) + k] = wdata[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_model[int'(addr[11:0]) + k];
        if (!uns && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (!uns && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
        e.rdata = v;
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Drive a request through its accepting edge without expecting a response.
  task automatic raw_req(input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = 1'b0;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [1:0]  sz;
    logic [31:0] a;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload every word the test reads, back to back.
    for (int w = 0; w < 12; w++) do_req("preload", 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h5A00_0000 ^ (32'h0103_0507 * 32'(w + 1)));
    do_req("preload_top", 1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'h8765_4321);

    // Word, byte and half accesses with extension.
    do_req("sw_010",  1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF);
    do_req("lw_010",  1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
    do_req("lb_013",  1'b0, 2'd0, 1'b0, 32'h013, 32'd0);
    do_req("lbu_013", 1'b0, 2'd0, 1'b1, 32'h013, 32'd0);
    do_req("lh_012",  1'b0, 2'd1, 1'b0, 32'h012, 32'd0);
    do_req("lhu_012", 1'b0, 2'd1, 1'b1, 32'h012, 32'd0);
    do_req("sb_011",  1'b1, 2'd0, 1'b0, 32'h011, 32'h0000_0055);
    do_req("lw_010b", 1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
    drain();

`ifdef DMEM_MISALIGN_EN
    do_req("sw_023", 1'b1, 2'd2, 1'b0, 32'h023, 32'h1122_3344);
    check("split_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("split_ready_back", {31'd0, req_ready}, 32'd1);
    do_req("lw_023", 1'b0, 2'd2, 1'b0, 32'h023, 32'd0);
    do_req("lw_020", 1'b0, 2'd2, 1'b0, 32'h020, 32'd0);
    do_req("lw_024", 1'b0, 2'd2, 1'b0, 32'h024, 32'd0);
    do_req("lh_007", 1'b0, 2'd1, 1'b0, 32'h007, 32'd0);
`endif
    do_req("lh_003", 1'b0, 2'd1, 1'b0, 32'h003, 32'd0);
    do_req("lw_000", 1'b0, 2'd2, 1'b0, 32'h000, 32'd0);

    // Faults: out of range, upper address bits, reserved size, split over the end.
    do_req("lw_1000",   1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0);
    do_req("lw_hibits", 1'b0, 2'd2, 1'b0, 32'h0001_0010, 32'd0);
    do_req("ld_size3",  1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'd0);
    do_req("sw_ffe",    1'b1, 2'd2, 1'b0, 32'h0000_0FFE, 32'hA1B2_C3D4);
    do_req("lh_ffe",    1'b0, 2'd1, 1'b0, 32'h0000_0FFE, 32'd0);
    do_req("lw_ffc",    1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'd0);

    // Random mix within the preloaded region, with occasional idle cycles.
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 16'h2C));
      do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    // Reset while a response is pending: the pulse is dropped.
    raw_req(1'b0, 2'd2, 32'h010, 32'd0);
    check("pend_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_rel_ready", {31'd0, req_ready}, 32'd1);

`ifdef DMEM_MISALIGN_EN
    // Reset during the second beat: beat-1 bytes commit, beat-2 bytes are lost.
    @(posedge clk); #1;
    raw_req(1'b1, 2'd2, 32'h025, 32'hCAFE_F00D);
    check("beat2_ready_low", {31'd0, req_ready}, 32'd0);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_model[16'h025] = 8'h0D;
    mem_model[16'h026] = 8'hF0;
    mem_model[16'h027] = 8'hFE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("beat2_rst_ready", {31'd0, req_ready}, 32'd1);
    check("beat2_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    do_req("lw_024_after_rst", 1'b0, 2'd2, 1'b0, 32'h024, 32'd0);
    do_req("lw_028_after_rst", 1'b0, 2'd2, 1'b0, 32'h028, 32'd0);
`endif
    do_req("lw_010_after_rst", 1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
